// File: rtl/pc_unit_pkg.sv
// Shared constants for the program-counter unit: next-PC select encodings and FSM states.
package pc_unit_pkg;

    localparam int PC_SEL_LEN = 3;

    localparam logic [PC_SEL_LEN-1:0] PC_PLUS4  = 3'd0;
    localparam logic [PC_SEL_LEN-1:0] PC_JAL    = 3'd1;
    localparam logic [PC_SEL_LEN-1:0] PC_JALR   = 3'd2;
    localparam logic [PC_SEL_LEN-1:0] PC_BRANCH = 3'd3;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_unit_target.sv
// Combinational next-PC target: selects and adds the offset for sequential, jump and branch flow.
module pc_target
    import pc_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [PC_SEL_LEN-1:0] sel,
    input  logic                  branch_taken,
    input  logic [XLEN-1:0]       imm_i,
    input  logic [XLEN-1:0]       imm_b,
    input  logic [XLEN-1:0]       imm_j,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       step,
    output logic [XLEN-1:0]       target
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rs1_data + imm_i;

    // All sums wrap naturally at XLEN bits; unrecognised selects fall back to sequential flow.
    always_comb begin
        target = pc + step;
        case (sel)
            PC_JAL:    target = pc + imm_j;
            PC_JALR:   target = {jalr_sum[XLEN-1:1], 1'b0};
            PC_BRANCH: target = branch_taken ? (pc + imm_b) : (pc + step);
            default:   target = pc + step;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot sequencing, fetch handshake, trap/xRET redirect and misalignment halt.
//   state | meaning
//   BOOT  | pc forced to RESET_VECTOR, not yet presented to fetch
//   RUN   | pc presented; advances on each accepted fetch
//   HALT  | misaligned target seen; pc frozen until trap or trap_return
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PC_SEL_LEN-1:0] sel,
    input  logic                  branch_taken,
    input  logic [XLEN-1:0]       imm_i,
    input  logic [XLEN-1:0]       imm_b,
    input  logic [XLEN-1:0]       imm_j,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic                  inst_compressed,
    input  logic                  stall,
    input  logic                  trap,
    input  logic [XLEN-1:0]       trap_vector,
    input  logic                  trap_return,
    input  logic [XLEN-1:0]       epc,
    input  logic                  fetch_ready,
    output logic [XLEN-1:0]       pc,
    output logic                  pc_valid,
    output logic                  misaligned,
    output logic [XLEN-1:0]       misaligned_addr
);

    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 16) ? ~XLEN'(1) : ~XLEN'(3);

    pc_state_e       state, state_next;
    logic [XLEN-1:0] pc_next, mis_addr_next, step, target;
    logic            mis_next, accept, target_bad;

    assign step     = (IALIGN == 16 && inst_compressed) ? XLEN'(2) : XLEN'(4);
    assign pc_valid = (state == RUN);
    assign accept   = pc_valid & fetch_ready & ~stall;

    pc_target #(.XLEN(XLEN)) u_target (
        .sel          (sel),
        .branch_taken (branch_taken),
        .imm_i        (imm_i),
        .imm_b        (imm_b),
        .imm_j        (imm_j),
        .rs1_data     (rs1_data),
        .pc           (pc),
        .step         (step),
        .target       (target)
    );

    assign target_bad = (IALIGN == 16) ? target[0] : target[1];

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        mis_next      = 1'b0;
        mis_addr_next = misaligned_addr;
        case (state)
            BOOT: begin
                pc_next    = RESET_VECTOR;
                state_next = RUN;
            end
            RUN, HALT: begin
                // Redirects win over everything, so misaligned can never pulse alongside them.
                if (trap) begin
                    pc_next    = trap_vector & ALIGN_MASK;
                    state_next = RUN;
                end else if (trap_return) begin
                    pc_next    = epc & ALIGN_MASK;
                    state_next = RUN;
                end else if (accept) begin
                    if (target_bad) begin
                        mis_next      = 1'b1;
                        mis_addr_next = target;
                        state_next    = HALT;
                    end else begin
                        pc_next = target;
                    end
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= BOOT;
            pc              <= RESET_VECTOR;
            misaligned      <= 1'b0;
            misaligned_addr <= '0;
        end else begin
            state           <= state_next;
            pc              <= pc_next;
            misaligned      <= mis_next;
            misaligned_addr <= mis_addr_next;
        end
    end

endmodule
